// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, widths and key codes for the game sequencer
package game_pkg;
  typedef enum logic [3:0] {
    WAIT = 4'b1000,
    PLAY = 4'b0100,
    WIN  = 4'b0010,
    LOSE = 4'b0001
  } status_t;
  localparam int SCORE_W = 8;
  localparam int RESULT_W = 10;
  localparam int PLAY_W = 16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
endpackage

// File: rtl/game_state_controller_rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector with a combinational pulse
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge Clk) q <= Reset ? 1'b0 : d;
  assign rise = d & ~q;
endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: round sequencer (wait/play/win/lose), score keeping and round reset.
// Optional GAME_TIMER_EN adds a play-time limit that forces LOSE.
module game_state_controller
  import game_pkg::*;
#(
  parameter int WIN_COINS = 10,
  parameter int RESULT_FRAMES = 180,
  parameter int TIME_LIMIT_FRAMES = 3600,
  parameter logic [7:0] START_KEY = KEY_SPACE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       coin_hit,
  input  logic       collision,
  output logic [3:0] status,
  output logic [7:0] score,
  output logic       game_reset,
  output logic       frame_tick
);
  localparam logic [3:0] S_WAIT = WAIT;
  localparam logic [3:0] S_PLAY = PLAY;
  localparam logic [3:0] S_WIN = WIN;
  localparam logic [3:0] S_LOSE = LOSE;
  logic [7:0] key_q;
  logic [RESULT_W-1:0] result_cnt, result_inc;
  logic [SCORE_W-1:0] score_inc;
  logic start_edge, win_hit, result_done, time_up;
  rise_detect u_frame (.Clk(Clk), .Reset(Reset), .d(frame_clk), .rise(frame_tick));
  assign start_edge = (keycode == START_KEY) && (key_q != START_KEY);
  assign score_inc = score + 1'b1;
  assign result_inc = result_cnt + 1'b1;
  assign win_hit = score_inc == SCORE_W'(WIN_COINS);
  assign result_done = result_inc == RESULT_W'(RESULT_FRAMES);
`ifdef GAME_TIMER_EN
  logic [PLAY_W-1:0] play_cnt, play_inc;
  assign play_inc = play_cnt + 1'b1;
  assign time_up = frame_tick && status == S_PLAY && play_inc == PLAY_W'(TIME_LIMIT_FRAMES);
  always_ff @(posedge Clk)
    if (Reset || status != S_PLAY) play_cnt <= '0;
    else if (frame_tick) play_cnt <= play_inc;
`else
  assign time_up = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      status <= S_WAIT;
      score <= '0;
      game_reset <= 1'b0;
      key_q <= '0;
      result_cnt <= '0;
    end else begin
      key_q <= keycode;
      game_reset <= 1'b0;
      case (status)
        S_WAIT: if (start_edge) begin
          status <= S_PLAY;
          score <= '0;
          game_reset <= 1'b1;
        end
        S_PLAY: if (collision || time_up) begin
          status <= S_LOSE;
          result_cnt <= '0;
        end else if (coin_hit) begin
          score <= score_inc;
          if (win_hit) begin
            status <= S_WIN;
            result_cnt <= '0;
          end
        end
        S_WIN, S_LOSE: if (frame_tick) begin
          result_cnt <= result_inc;
          if (result_done) status <= S_WAIT;
        end
        default: status <= S_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed self-checking bench for game_state_controller
module tb_game_state_controller;
  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, coin_hit = 1'b0, collision = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [3:0] status;
  logic [7:0] score;
  logic game_reset, frame_tick;
  int checks = 0, errors = 0;

  game_state_controller #(.WIN_COINS(3), .RESULT_FRAMES(2), .TIME_LIMIT_FRAMES(4), .START_KEY(8'h2C)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .coin_hit(coin_hit),
    .collision(collision), .status(status), .score(score), .game_reset(game_reset), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic start_round();
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL reset_status got %b want 1000", status); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL reset_game_reset got %b want 0", game_reset); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_frame_tick();
    frame_clk = 1'b1;
    #1;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_rise got %b want 1", frame_tick); end
    step();
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_held got %b want 0", frame_tick); end
    frame_clk = 1'b0;
    step();
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL tick_wait got %b want 1000", status); end
  endtask

  task automatic test_start();
    keycode = 8'h2C;
    step();
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL start_status got %b want 0100", status); end
    checks++; if (game_reset !== 1'b1) begin errors++; $display("FAIL start_pulse got %b want 1", game_reset); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL start_score got %0d want 0", score); end
    keycode = 8'h00;
    step();
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL start_pulse_end got %b want 0", game_reset); end
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL start_stay got %b want 0100", status); end
  endtask

  task automatic test_win();
    for (int i = 1; i <= 3; i++) begin
      coin_hit = 1'b1;
      step();
      coin_hit = 1'b0;
      checks++; if (score !== 8'(i)) begin errors++; $display("FAIL win_score%0d got %0d want %0d", i, score, i); end
      step();
    end
    checks++; if (status !== 4'b0010) begin errors++; $display("FAIL win_status got %b want 0010", status); end
    collision = 1'b1;
    coin_hit = 1'b1;
    keycode = 8'h2C;
    step();
    collision = 1'b0;
    coin_hit = 1'b0;
    keycode = 8'h00;
    checks++; if (status !== 4'b0010 || score !== 8'd3) begin errors++; $display("FAIL win_ignore got %b/%0d want 0010/3", status, score); end
    frame();
    checks++; if (status !== 4'b0010) begin errors++; $display("FAIL win_hold got %b want 0010", status); end
    frame();
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL win_return got %b want 1000", status); end
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL win_keep_score got %0d want 3", score); end
  endtask

  task automatic test_hold_start();
    int pulses;
    start_round();
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL hold_clear_score got %0d want 0", score); end
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if (status !== 4'b0001) begin errors++; $display("FAIL hold_lose got %b want 0001", status); end
    frame();
    frame();
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL hold_wait got %b want 1000", status); end
    pulses = 0;
    keycode = 8'h2C;
    for (int i = 0; i < 100; i++) begin
      step();
      if (game_reset === 1'b1) pulses++;
    end
    keycode = 8'h00;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL hold_play got %b want 0100", status); end
    step();
  endtask

  task automatic test_tie();
    for (int i = 0; i < 2; i++) begin
      coin_hit = 1'b1;
      step();
      coin_hit = 1'b0;
      step();
    end
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL tie_pre_score got %0d want 2", score); end
    coin_hit = 1'b1;
    collision = 1'b1;
    step();
    coin_hit = 1'b0;
    collision = 1'b0;
    checks++; if (status !== 4'b0001) begin errors++; $display("FAIL tie_status got %b want 0001", status); end
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL tie_score got %0d want 2", score); end
    frame();
    frame();
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL tie_return got %b want 1000", status); end
  endtask

  task automatic test_timer();
    start_round();
`ifdef GAME_TIMER_EN
    for (int i = 0; i < 3; i++) frame();
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL timer_before got %b want 0100", status); end
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    checks++; if (status !== 4'b0001) begin errors++; $display("FAIL timer_lose got %b want 0001", status); end
    step();
    frame();
    frame();
`else
    for (int i = 0; i < 10; i++) frame();
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL timer_none got %b want 0100", status); end
    collision = 1'b1;
    step();
    collision = 1'b0;
    frame();
    frame();
`endif
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL timer_return got %b want 1000", status); end
  endtask

  task automatic test_mid_reset();
    start_round();
    for (int i = 0; i < 2; i++) begin
      coin_hit = 1'b1;
      step();
      coin_hit = 1'b0;
      step();
    end
    checks++; if (score !== 8'd2 || status !== 4'b0100) begin errors++; $display("FAIL mrst_pre got %b/%0d want 0100/2", status, score); end
    Reset = 1'b1;
    keycode = 8'h2C;
    step();
    checks++; if (status !== 4'b1000) begin errors++; $display("FAIL mrst_status got %b want 1000", status); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL mrst_score got %0d want 0", score); end
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL mrst_pulse got %b want 0", game_reset); end
    Reset = 1'b0;
    keycode = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_start();
    test_win();
    test_hold_start();
    test_tie();
    test_timer();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_state_controller.md
# game_state_controller

Top-level game sequencer for the stickman runner. Owns the one-hot `status` vector that drives the colour mapper's screen selection, and starts rounds from the keyboard. Keeps the round's coin score and decides win or lose from coin and collision events. Sits between the keyboard/collision/coin logic and the colour mapper, and pulses a round reset to the stickman, coin and ground modules.

## Interface
Parameters:
- `WIN_COINS`, 10 — coins needed to win; legal range 1..255.
- `RESULT_FRAMES`, 180 — frames the win or lose screen is held before returning to waiting; legal range 1..1023.
- `TIME_LIMIT_FRAMES`, 3600 — playing-time limit in frames; legal range 1..65535; used only with `GAME_TIMER_EN`.
- `START_KEY`, 8'h2C — keycode that starts a round (space).

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock (50 MHz).
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk`  in  1  VGA vertical sync, synchronous to `Clk`; its rising edge marks one frame.
- `keycode`  in  8  current keyboard keycode; 0 means no key is pressed.
- `coin_hit`  in  1  one-`Clk` pulse each time the stickman collects a coin.
- `collision`  in  1  level signal: the stickman overlaps an obstacle or has fallen.
- `status`  out  4  one-hot {waiting, playing, win, lose}; drives the colour mapper.
- `score`  out  8  coins collected in the current or last round.
- `game_reset`  out  1  one-`Clk` pulse at the start of each round.
- `frame_tick`  out  1  one-`Clk` pulse on each rising edge of `frame_clk`.

## Operation
- Frame tick: register `frame_clk` into `fc_q`.
  - `frame_tick = frame_clk & ~fc_q`.
- Start edge: register `keycode` into `key_q`.
  - `start_edge = (keycode == START_KEY) && (key_q != START_KEY)`.
  - Holding the key down does not retrigger a start.
- State machine. The state encoding equals `status`.
  - WAIT (4'b1000): on `start_edge`, go to PLAY, clear `score` to 0, and assert `game_reset` for one cycle.
  - PLAY (4'b0100):
    - `collision` = 1 → LOSE.
    - Otherwise, `coin_hit` increments `score`.
    - When the incremented score equals `WIN_COINS` → WIN.
    - If `collision` and the winning `coin_hit` occur in the same cycle, LOSE wins and `score` does not increment.
  - WIN (4'b0010) and LOSE (4'b0001):
    - `result_cnt` counts `frame_tick`s from 0.
    - When the tick brings the count to `RESULT_FRAMES` → WAIT.
    - `start_edge`, `coin_hit` and `collision` are ignored.
    - `score` holds its value.
- `result_cnt` (10-bit) is cleared on every entry into WIN or LOSE.
- `score` never exceeds `WIN_COINS`.
- `coin_hit` is ignored outside PLAY.
- An illegal state (not one-hot) returns to WAIT on the next edge.

## Timing
- Reset values: `status`=4'b1000, `score`=0, `game_reset`=0, `frame_tick`=0, all counters 0, `fc_q`=0, `key_q`=0.
- `Reset` asserted mid-round: WAIT on the next `Clk` edge, with no `game_reset` pulse.
- All outputs are registered except `frame_tick`, which is combinational from `frame_clk` and `fc_q`.
- Start: `status`=PLAY and `game_reset`=1 in the cycle after the first cycle in which `keycode`==`START_KEY`.
  - `game_reset` is high for exactly one cycle.
- `coin_hit` → `score` is updated one cycle later.
- A win or lose transition is visible on `status` one cycle after the triggering input.
- Result hold: `status` returns to 4'b1000 one cycle after the `RESULT_FRAMES`-th `frame_tick` following entry.

## Configuration
- `GAME_TIMER_EN` defined:
  - A 16-bit `play_cnt` clears on entry to PLAY and counts `frame_tick`s.
  - Reaching `TIME_LIMIT_FRAMES` → LOSE.
  - `collision` and a winning coin in the same cycle as the timeout: priority is collision > timeout > win.
- `GAME_TIMER_EN` undefined: no `play_cnt`, and PLAY has no time limit.

## Structure
- Package `game_pkg`:
  - `status_t` enum: WAIT=4'b1000, PLAY=4'b0100, WIN=4'b0010, LOSE=4'b0001.
  - Width constants for score and counters.
  - `KEY_SPACE` = 8'h2C.
- Sub-module `rise_detect` (1-bit registered rising-edge detector, `Clk`/`Reset`). Instantiated for `frame_clk`; the start-key edge uses the equality-compare form inline.

## Test plan
- Reset release, then `keycode`=8'h2C for one cycle → `status` 4'b1000→4'b0100 next cycle, `game_reset` high for exactly one cycle, `score`=0.
- `keycode` held at 8'h2C for 100 cycles while in WAIT after a lose → exactly one start, no repeated `game_reset`.
- `WIN_COINS`=3, three `coin_hit` pulses → `score` 1,2,3, `status`=4'b0010. After `RESULT_FRAMES`=2 frame ticks → 4'b1000, with `score` still 3.
- `score`=2 (`WIN_COINS`=3), `coin_hit` and `collision` in the same cycle → `status`=4'b0001, `score` stays 2.
- `Reset` asserted in PLAY with `score`=5 → next cycle `status`=4'b1000, `score`=0, `game_reset`=0.
- `GAME_TIMER_EN`, `TIME_LIMIT_FRAMES`=4, no coins → `status`=4'b0001 one cycle after the 4th `frame_tick` in PLAY. Without the macro: still PLAY after 10 ticks.
